// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind the UART receiver: SYNC/CMD/LEN/PAYLOAD/CHK sequencing, payload buffer,
// one-frame hold under valid/ack, saturating error count for framing, receiver and timeout faults.
module uart_rx_frame_ctrl #(
  parameter int         MAX_LEN        = 16,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 9548,
  parameter int         LEN_W          = $clog2(MAX_LEN+1),
  parameter int         TMR_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             rx_error,
  input  logic             frame_ack,
  input  logic [LEN_W-1:0] rd_addr,
  output logic [7:0]       rd_data,
  output logic             frame_valid,
  output logic             frame_pending,
  output logic [7:0]       frame_cmd,
  output logic [LEN_W-1:0] frame_len,
  output logic             busy,
  output logic             overrun,
  output logic [7:0]       err_count,
  input  logic             err_clr
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CHK     = 3'd4,
    S_HOLD    = 3'd5
  } state_t;

  localparam logic [8:0]       MAX_LEN_B = 9'(MAX_LEN);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_d;
  logic [7:0]       chk;
  logic [LEN_W-1:0] idx;
  logic [TMR_W-1:0] tmr, tmr_d;
  logic [7:0]       pay_buf [MAX_LEN];

  logic err_inc, ld_cmd, ld_len, wr_pay, fv_d, ovr_d, timeout, in_frame;

  assign in_frame      = (state == S_CMD) || (state == S_LEN) ||
                         (state == S_PAYLOAD) || (state == S_CHK);
  assign busy          = in_frame;
  assign frame_pending = (state == S_HOLD);
  assign timeout       = in_frame && (tmr == TMR_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_d;
  end

  // Receiver error always wins over a same-cycle byte; a byte wins over an expiring timer.
  always_comb begin
    state_d = state;
    err_inc = 1'b0;
    ld_cmd  = 1'b0;
    ld_len  = 1'b0;
    wr_pay  = 1'b0;
    fv_d    = 1'b0;
    ovr_d   = 1'b0;
    tmr_d   = '0;
    case (state)
      S_IDLE: begin
        if (rx_error)                                err_inc = 1'b1;
        else if (rx_valid && rx_data == SYNC_BYTE)   state_d = S_CMD;
      end
      S_CMD, S_LEN, S_PAYLOAD, S_CHK: begin
        if (rx_error) begin
          err_inc = 1'b1;
          state_d = S_IDLE;
        end else if (rx_valid) begin
          case (state)
            S_CMD: begin
              ld_cmd  = 1'b1;
              state_d = S_LEN;
            end
            S_LEN: begin
              if ({1'b0, rx_data} > MAX_LEN_B) begin
                err_inc = 1'b1;
                state_d = S_IDLE;
              end else begin
                ld_len  = 1'b1;
                state_d = (rx_data == 8'd0) ? S_CHK : S_PAYLOAD;
              end
            end
            S_PAYLOAD: begin
              wr_pay = 1'b1;
              if (idx == frame_len - LEN_W'(1)) state_d = S_CHK;
            end
            default: begin
              if (rx_data == chk) begin
                fv_d    = 1'b1;
                state_d = S_HOLD;
              end else begin
                err_inc = 1'b1;
                state_d = S_IDLE;
              end
            end
          endcase
        end else if (timeout) begin
          err_inc = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr + TMR_W'(1);
        end
      end
      S_HOLD: begin
        if (rx_error)      err_inc = 1'b1;
        else if (rx_valid) ovr_d   = 1'b1;
        if (frame_ack)     state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cmd   <= '0;
      frame_len   <= '0;
      chk         <= '0;
      idx         <= '0;
      tmr         <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
      err_count   <= '0;
    end else begin
      tmr         <= tmr_d;
      frame_valid <= fv_d;
      overrun     <= ovr_d;
      if (ld_cmd) begin
        frame_cmd <= rx_data;
        chk       <= rx_data;
      end
      if (ld_len) begin
        frame_len <= LEN_W'(rx_data);
        chk       <= chk ^ rx_data;
        idx       <= '0;
      end
      if (wr_pay) begin
        chk <= chk ^ rx_data;
        idx <= idx + LEN_W'(1);
      end
      if (err_clr)                         err_count <= '0;
      else if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  // Payload store is left untouched between frames; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_LEN; i++) pay_buf[i] <= '0;
    end else if (wr_pay) begin
      for (int i = 0; i < MAX_LEN; i++)
        if (idx == LEN_W'(i)) pay_buf[i] <= rx_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < MAX_LEN; i++)
      if (rd_addr == LEN_W'(i)) rd_data = pay_buf[i];
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: one task per scenario, inline checks, single summary line.
module tb_uart_rx_frame_ctrl;

  localparam int MAX_LEN        = 16;
  localparam int TIMEOUT_CYCLES = 9548;
  localparam int LEN_W          = $clog2(MAX_LEN+1);

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [7:0]       rx_data = '0;
  logic             rx_valid = 1'b0;
  logic             rx_error = 1'b0;
  logic             frame_ack = 1'b0;
  logic [LEN_W-1:0] rd_addr = '0;
  logic [7:0]       rd_data;
  logic             frame_valid, frame_pending, busy, overrun, err_clr;
  logic [7:0]       frame_cmd, err_count;
  logic [LEN_W-1:0] frame_len;

  int tests = 0;
  int fails = 0;
  int exp_err = 0;

  initial err_clr = 1'b0;

  uart_rx_frame_ctrl #(
    .MAX_LEN(MAX_LEN), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_error(rx_error), .frame_ack(frame_ack), .rd_addr(rd_addr),
    .rd_data(rd_data), .frame_valid(frame_valid), .frame_pending(frame_pending),
    .frame_cmd(frame_cmd), .frame_len(frame_len), .busy(busy),
    .overrun(overrun), .err_count(err_count), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // All stimulus changes at the falling edge; the caller is already at a falling edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_rx_error();
    rx_error = 1'b1;
    @(negedge clk);
    rx_error = 1'b0;
  endtask

  task automatic do_ack();
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
  endtask

  task automatic send_good();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h32);
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b want 0", busy); end
    tests++; if (frame_pending !== 1'b0 || frame_valid !== 1'b0) begin fails++;
      $display("FAIL reset_frame: pending %0b valid %0b want 0 0", frame_pending, frame_valid); end
    tests++; if (frame_cmd !== 8'h00 || frame_len !== '0) begin fails++;
      $display("FAIL reset_regs: cmd %0h len %0d want 0 0", frame_cmd, frame_len); end
    tests++; if (err_count !== 8'd0 || overrun !== 1'b0 || rd_data !== 8'h00) begin fails++;
      $display("FAIL reset_misc: err %0d ovr %0b rd %0h want 0 0 0", err_count, overrun, rd_data); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_good_frame();
    send_good();
    tests++; if (frame_valid !== 1'b1 || frame_pending !== 1'b1) begin fails++;
      $display("FAIL good_valid: valid %0b pending %0b want 1 1", frame_valid, frame_pending); end
    tests++; if (frame_cmd !== 8'h03 || frame_len !== 5'd2) begin fails++;
      $display("FAIL good_hdr: cmd %0h len %0d want 03 2", frame_cmd, frame_len); end
    rd_addr = 5'd0; #1;
    tests++; if (rd_data !== 8'h11) begin fails++; $display("FAIL good_rd0: got %0h want 11", rd_data); end
    rd_addr = 5'd1; #1;
    tests++; if (rd_data !== 8'h22) begin fails++; $display("FAIL good_rd1: got %0h want 22", rd_data); end
    @(negedge clk);
    tests++; if (frame_valid !== 1'b0 || frame_pending !== 1'b1) begin fails++;
      $display("FAIL good_pulse: valid %0b pending %0b want 0 1", frame_valid, frame_pending); end
    tests++; if (err_count !== 8'(exp_err)) begin fails++; $display("FAIL good_err: got %0d want %0d", err_count, exp_err); end
    do_ack();
    tests++; if (frame_pending !== 1'b0) begin fails++; $display("FAIL good_ack: pending %0b want 0", frame_pending); end
  endtask

  task automatic test_bad_checksum();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    exp_err++;
    tests++; if (frame_valid !== 1'b0 || frame_pending !== 1'b0) begin fails++;
      $display("FAIL badchk_valid: valid %0b pending %0b want 0 0", frame_valid, frame_pending); end
    tests++; if (err_count !== 8'(exp_err) || busy !== 1'b0) begin fails++;
      $display("FAIL badchk_err: err %0d busy %0b want %0d 0", err_count, busy, exp_err); end
    test_good_frame();
  endtask

  task automatic test_len_bounds();
    send_byte(8'hA5); send_byte(8'h07); send_byte(8'h00); send_byte(8'h07);
    tests++; if (frame_valid !== 1'b1 || frame_len !== 5'd0 || frame_cmd !== 8'h07) begin fails++;
      $display("FAIL zero_len: valid %0b len %0d cmd %0h want 1 0 07", frame_valid, frame_len, frame_cmd); end
    do_ack();
    send_byte(8'hA5); send_byte(8'h07); send_byte(8'h11);
    exp_err++;
    tests++; if (err_count !== 8'(exp_err) || busy !== 1'b0) begin fails++;
      $display("FAIL oversize: err %0d busy %0b want %0d 0", err_count, busy, exp_err); end
    // 16 is the largest legal length and must be accepted
    send_byte(8'hA5); send_byte(8'h07); send_byte(8'h10);
    tests++; if (busy !== 1'b1 || err_count !== 8'(exp_err)) begin fails++;
      $display("FAIL max_len: busy %0b err %0d want 1 %0d", busy, err_count, exp_err); end
    pulse_rx_error();
    exp_err++;
  endtask

  task automatic test_timeout();
    send_byte(8'hA5); send_byte(8'h03);
    repeat (TIMEOUT_CYCLES - 1) @(negedge clk);
    tests++; if (busy !== 1'b1 || err_count !== 8'(exp_err)) begin fails++;
      $display("FAIL timeout_early: busy %0b err %0d want 1 %0d", busy, err_count, exp_err); end
    @(negedge clk);
    exp_err++;
    tests++; if (busy !== 1'b0 || err_count !== 8'(exp_err)) begin fails++;
      $display("FAIL timeout: busy %0b err %0d want 0 %0d", busy, err_count, exp_err); end
    send_byte(8'h02);
    @(negedge clk);
    tests++; if (busy !== 1'b0 || err_count !== 8'(exp_err)) begin fails++;
      $display("FAIL timeout_late: busy %0b err %0d want 0 %0d", busy, err_count, exp_err); end
  endtask

  task automatic test_hold_overrun();
    send_good();
    @(negedge clk);
    send_byte(8'hA5);
    tests++; if (overrun !== 1'b1 || frame_pending !== 1'b1) begin fails++;
      $display("FAIL overrun: ovr %0b pending %0b want 1 1", overrun, frame_pending); end
    @(negedge clk);
    tests++; if (overrun !== 1'b0 || frame_cmd !== 8'h03) begin fails++;
      $display("FAIL overrun_pulse: ovr %0b cmd %0h want 0 03", overrun, frame_cmd); end
    rx_data = 8'h5A; rx_valid = 1'b1; frame_ack = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; frame_ack = 1'b0;
    tests++; if (overrun !== 1'b1 || frame_pending !== 1'b0 || busy !== 1'b0) begin fails++;
      $display("FAIL ack_overrun: ovr %0b pending %0b busy %0b want 1 0 0", overrun, frame_pending, busy); end
    send_byte(8'hA5); send_byte(8'h09); send_byte(8'h01);
    send_byte(8'h5A); send_byte(8'h52);
    tests++; if (frame_valid !== 1'b1 || frame_cmd !== 8'h09 || frame_len !== 5'd1) begin fails++;
      $display("FAIL next_frame: valid %0b cmd %0h len %0d want 1 09 1", frame_valid, frame_cmd, frame_len); end
    rd_addr = 5'd0; #1;
    tests++; if (rd_data !== 8'h5A) begin fails++; $display("FAIL next_rd0: got %0h want 5a", rd_data); end
    rd_addr = 5'd1; #1;
    tests++; if (rd_data !== 8'h22) begin fails++; $display("FAIL stale_rd1: got %0h want 22", rd_data); end
    rd_addr = 5'd20; #1;
    tests++; if (rd_data !== 8'h00) begin fails++; $display("FAIL rd_oob: got %0h want 00", rd_data); end
    @(negedge clk);
    do_ack();
  endtask

  task automatic test_rx_error();
    send_byte(8'hA5); send_byte(8'h03);
    pulse_rx_error();
    exp_err++;
    tests++; if (err_count !== 8'(exp_err) || busy !== 1'b0) begin fails++;
      $display("FAIL rxerr_frame: err %0d busy %0b want %0d 0", err_count, busy, exp_err); end
    send_good();
    rx_data = 8'hA5; rx_valid = 1'b1; rx_error = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; rx_error = 1'b0;
    exp_err++;
    tests++; if (err_count !== 8'(exp_err) || frame_pending !== 1'b1 || overrun !== 1'b0) begin fails++;
      $display("FAIL rxerr_hold: err %0d pending %0b ovr %0b want %0d 1 0", err_count, frame_pending, overrun, exp_err); end
    do_ack();
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h02); send_byte(8'h11);
    rd_addr = 5'd0;
    #2 reset = 1'b0;
    #1;
    exp_err = 0;
    tests++; if (busy !== 1'b0 || frame_pending !== 1'b0 || frame_valid !== 1'b0) begin fails++;
      $display("FAIL rst_mid_state: busy %0b pending %0b valid %0b want 0 0 0", busy, frame_pending, frame_valid); end
    tests++; if (frame_cmd !== 8'h00 || frame_len !== '0 || err_count !== 8'd0 || rd_data !== 8'h00) begin fails++;
      $display("FAIL rst_mid_regs: cmd %0h len %0d err %0d rd %0h want 0 0 0 0", frame_cmd, frame_len, err_count, rd_data); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_err_saturate();
    rx_error = 1'b1;
    repeat (260) @(negedge clk);
    rx_error = 1'b0;
    tests++; if (err_count !== 8'd255) begin fails++; $display("FAIL sat: got %0d want 255", err_count); end
    pulse_rx_error();
    tests++; if (err_count !== 8'd255) begin fails++; $display("FAIL sat_hold: got %0d want 255", err_count); end
    err_clr = 1'b1; rx_error = 1'b1;
    @(negedge clk);
    err_clr = 1'b0; rx_error = 1'b0;
    tests++; if (err_count !== 8'd0) begin fails++; $display("FAIL err_clr: got %0d want 0", err_count); end
    pulse_rx_error();
    tests++; if (err_count !== 8'd1) begin fails++; $display("FAIL after_clr: got %0d want 1", err_count); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_len_bounds();
    test_timeout();
    test_hold_overrun();
    test_rx_error();
    test_reset_mid_frame();
    test_err_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_ctrl.md
# uart_rx_frame_ctrl

Frame-level controller that sits directly behind the UART receiver. It consumes the receiver's `rx_data`/`rx_valid`/`rx_error` byte stream and sequences it through a framing state machine (sync, command, length, payload, checksum). It buffers the payload and presents each checksum-verified frame to the command logic under a valid/ack handshake. Framing errors, receiver errors and inter-byte timeouts are counted in a saturating error counter.

## Interface

**Parameters**
- `MAX_LEN`, default 16: maximum payload bytes per frame; size of the payload buffer.
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `TIMEOUT_CYCLES`, default 9548: inter-byte timeout in clk cycles (2 characters × 11 bits × 434 cycles).
- `LEN_W`, default $clog2(MAX_LEN+1): width of the length field and index.
- `TMR_W`, default $clog2(TIMEOUT_CYCLES): width of the timeout counter.

**Ports**
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, asynchronous, active-low.
- `rx_data`, in, 8: received byte; qualified by `rx_valid`.
- `rx_valid`, in, 1: one-cycle pulse, byte received without error.
- `rx_error`, in, 1: one-cycle pulse, receiver parity/stop error.
- `frame_ack`, in, 1: consumer releases the held frame.
- `rd_addr`, in, LEN_W: payload buffer read index.
- `rd_data`, out, 8: combinational `buf[rd_addr]`; 0 when `rd_addr >= MAX_LEN`.
- `frame_valid`, out, 1: one-cycle pulse, good frame captured.
- `frame_pending`, out, 1: level, frame held awaiting `frame_ack`.
- `frame_cmd`, out, 8: command byte of the held frame.
- `frame_len`, out, LEN_W: payload length of the held frame.
- `busy`, out, 1: frame reception in progress (states CMD..CHK).
- `overrun`, out, 1: one-cycle pulse, byte dropped while in HOLD.
- `err_count`, out, 8: saturating error count.
- `err_clr`, in, 1: synchronous clear of `err_count`.

## Operation

**States:** IDLE, CMD, LEN, PAYLOAD, CHK, HOLD. On reset the FSM is in IDLE.

**Transitions**
- **IDLE:**
  - `rx_valid` with `rx_data == SYNC_BYTE` → CMD.
  - Any other byte is ignored and does not count as an error.
- **CMD:** `rx_valid` → latch `frame_cmd`, set `chk = rx_data` → LEN.
- **LEN:** on `rx_valid`:
  - `rx_data > MAX_LEN` → error, then IDLE.
  - Otherwise:
    - latch `frame_len`;
    - `chk ^= rx_data`;
    - `idx = 0`;
    - go to CHK if length is 0, else PAYLOAD.
- **PAYLOAD:** on `rx_valid`:
  - `buf[idx] = rx_data`;
  - `chk ^= rx_data`;
  - `idx++`;
  - when `idx == frame_len-1` before the increment → CHK.
- **CHK:** on `rx_valid`:
  - `rx_data == chk` → HOLD, with `frame_valid` pulsed for exactly one cycle.
  - Otherwise → error, then IDLE.
- **HOLD:**
  - `frame_ack` → IDLE.
  - `rx_valid` → byte dropped, `overrun` pulses. This also applies in the same cycle as `frame_ack`.
  - `frame_ack` in any other state is ignored.

**Errors and abort rules**
- Error means `err_count` increments, saturating at 255.
- `rx_error` in CMD..CHK → error, then IDLE.
- `rx_error` in IDLE or HOLD → error only; the state is unchanged.
- If `rx_error` and `rx_valid` are both high, `rx_error` wins and the byte is discarded.
- `err_clr` has priority over a same-cycle increment; the result is 0.

**Timeout**
- The timer runs in CMD..CHK and clears on every accepted byte.
- Reaching `TIMEOUT_CYCLES-1` → error, then IDLE.
- The timer is held at 0 in IDLE and HOLD.

**Buffer and register rules**
- The buffer is not cleared between frames. Bytes beyond `frame_len` are stale.
- `frame_cmd`, `frame_len` and `buf` are stable throughout HOLD.

## Timing

**Reset values:**
- `frame_valid = 0`, `frame_pending = 0`, `frame_cmd = 0`, `frame_len = 0`, `busy = 0`, `overrun = 0`, `err_count = 0`;
- `buf` all 0, so `rd_data = 0`.

**Latency:**
- `frame_valid` asserts on the clk edge after the `rx_valid` cycle that carries the checksum byte.
- `frame_pending` rises in the same cycle as `frame_valid`.
- `frame_pending` falls on the clk edge after `frame_ack`.

**Output timing:**
- `busy`, `overrun` and `err_count` update on the edge after the causing input.
- `rd_data` is combinational; it has zero latency from `rd_addr`.

**Back-to-back traffic:**
- Bytes may arrive every cycle and each is consumed.
- No throughput limit exists other than HOLD.

**Reset mid-frame:** asynchronous return to IDLE, with all outputs at their reset values.

## Test plan

1. Good frame: bytes A5 03 02 11 22 32 → `frame_valid` pulses once; `frame_cmd = 03`; `frame_len = 2`; `rd_addr` 0 → 11 and 1 → 22; `err_count = 0`.
2. Bad checksum: A5 03 02 11 22 33 → no `frame_valid`; `err_count = 1`; `busy = 0`. A following good frame (test 1) is then accepted.
3. Zero length and oversize length:
   - A5 07 00 07 → `frame_valid` with `frame_len = 0`.
   - A5 07 11 → `err_count + 1`, back in IDLE.
4. Timeout: A5 03, then idle for `TIMEOUT_CYCLES` → `err_count + 1`, `busy` drops. A late byte 02 is ignored (not sync); no further error.
5. HOLD overrun and ack:
   - After test 1, send A5 without ack → `overrun` pulses once and `frame_pending` stays 1.
   - Assert `frame_ack` → `frame_pending = 0`. The next good frame is accepted.
6. Receiver error and reset:
   - Pulse `rx_error` after A5 03 → `err_count + 1`, IDLE.
   - Assert reset mid-PAYLOAD → all outputs return to their reset values immediately.
   - With `err_count = 255`, a further error leaves 255; `err_clr` → 0.
